// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: draws ranks from an LFSR (or forced test rank) into six card
// registers on sequencer strobes, computes hand scores and flags strobe-protocol violations.
module baccarat_datapath #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       new_hand,
  input  logic       force_en,
  input  logic [3:0] force_rank,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3_out,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [3:0] pcard3,
  output logic [2:0] cards_dealt,
  output logic       seq_error
);

  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LfsrMask = 16'hB400;

  logic [15:0]     lfsr_q, lfsr_d;
  logic [5:0][3:0] card_q, card_d;
  logic [2:0]      dealt_q, dealt_d;
  logic            err_q, err_d;

  logic [5:0] ld;
  logic [3:0] raw, rank;
  logic       multi, order_ok, tgt_empty;

  // Bit order: player 1-3 in [2:0], dealer 1-3 in [5:3].
  assign ld = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
  assign multi = (ld & (ld - 6'd1)) != 6'd0;

  function automatic logic [3:0] card_val(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd9) ? r : 4'd0;
  endfunction

  function automatic logic [3:0] score(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c);
    logic [4:0] s;
    s = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
    if (s >= 5'd20)      s = s - 5'd20;
    else if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  always_comb begin
    raw = force_en ? force_rank : lfsr_q[3:0];
    case (raw)
      4'd0:    rank = 4'd13;
      4'd14:   rank = 4'd11;
      4'd15:   rank = 4'd12;
      default: rank = raw;
    endcase
  end

  always_comb begin
    case (ld)
      6'b000001: order_ok = (dealt_q == 3'd0);
      6'b001000: order_ok = (dealt_q == 3'd1);
      6'b000010: order_ok = (dealt_q == 3'd2);
      6'b010000: order_ok = (dealt_q == 3'd3);
      6'b000100,
      6'b100000: order_ok = (dealt_q >= 3'd4);
      default:   order_ok = 1'b0;
    endcase
    tgt_empty = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ld[i]) tgt_empty = (card_q[i] == 4'd0);
    end
  end

  always_comb begin
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
    card_d  = card_q;
    dealt_d = dealt_q;
    err_d   = err_q;
    if (new_hand) begin
      card_d  = '0;
      dealt_d = 3'd0;
      err_d   = 1'b0;
    end else if (multi) begin
      err_d = 1'b1;
    end else if (ld != 6'd0) begin
      if (order_ok && tgt_empty) begin
        for (int i = 0; i < 6; i++) begin
          if (ld[i]) card_d[i] = rank;
        end
        dealt_d = (dealt_q == 3'd6) ? 3'd6 : dealt_q + 3'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      lfsr_q  <= SeedEff;
      card_q  <= '0;
      dealt_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      card_q  <= card_d;
      dealt_q <= dealt_d;
      err_q   <= err_d;
    end
  end

  assign pcard1      = card_q[0];
  assign pcard2      = card_q[1];
  assign pcard3_out  = card_q[2];
  assign pcard3      = card_q[2];
  assign dcard1      = card_q[3];
  assign dcard2      = card_q[4];
  assign dcard3      = card_q[5];
  assign pscore      = score(card_q[0], card_q[1], card_q[2]);
  assign dscore      = score(card_q[3], card_q[4], card_q[5]);
  assign cards_dealt = dealt_q;
  assign seq_error   = err_q;

endmodule
